// File: rtl/mips_core_pkg.sv
// Shared core types: the renamed-instruction record passed from rename into the issue queue,
// and the wrap-tolerant age comparison used by rename, the branch stack and the issue queue.
package mips_core_pkg;

    localparam int IQ_PREG_W = 6;
    localparam int IQ_CTR_W  = 32;

    typedef struct packed {
        logic [IQ_CTR_W-1:0]  count;
        logic [IQ_PREG_W-1:0] rs_phys;
        logic [IQ_PREG_W-1:0] rt_phys;
        logic [IQ_PREG_W-1:0] rw_phys;
        logic                 uses_rs;
        logic                 uses_rt;
        logic                 uses_rw;
        logic                 ready;
        logic [3:0]           alu_ctl;
        logic                 is_branch;
        logic                 mem_read;
        logic                 mem_write;
        logic [31:0]          imm;
        logic [31:0]          pc;
    } Instr_Queue_Entry_t;

    // a is older than b when (a - b) is negative in CTR_W-bit two's complement.
    function automatic logic is_older(input logic [IQ_CTR_W-1:0] a,
                                      input logic [IQ_CTR_W-1:0] b);
        logic [IQ_CTR_W-1:0] diff;
        diff = a - b;
        return diff[IQ_CTR_W-1];
    endfunction

endpackage

// File: rtl/iq_oldest_select.sv
// Oldest-request select: a binary tree of age comparators, purely combinational.
// Ties between equal counts resolve to the lower slot index.
module iq_oldest_select
    import mips_core_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]               req_i,
    input  logic [DEPTH-1:0][IQ_CTR_W-1:0] count_i,
    output logic [DEPTH-1:0]               grant_o,
    output logic                           any_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVLS  = $clog2(DEPTH);

    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        localparam int N = DEPTH >> l;
        logic [N-1:0]               vld;
        logic [N-1:0][IQ_CTR_W-1:0] ctr;
        logic [N-1:0][IDX_W-1:0]    idx;

        if (l == 0) begin : g_leaf
            assign vld = req_i;
            assign ctr = count_i;
            for (genvar g = 0; g < N; g++) begin : g_idx
                assign idx[g] = IDX_W'(g);
            end
        end else begin : g_node
            for (genvar n = 0; n < N; n++) begin : g_n
                logic take_hi;
                // The upper-index child wins only when strictly older.
                assign take_hi = g_lvl[l-1].vld[2*n+1] &&
                                 (!g_lvl[l-1].vld[2*n] ||
                                  is_older(g_lvl[l-1].ctr[2*n+1], g_lvl[l-1].ctr[2*n]));
                assign vld[n] = g_lvl[l-1].vld[2*n] | g_lvl[l-1].vld[2*n+1];
                assign ctr[n] = take_hi ? g_lvl[l-1].ctr[2*n+1] : g_lvl[l-1].ctr[2*n];
                assign idx[n] = take_hi ? g_lvl[l-1].idx[2*n+1] : g_lvl[l-1].idx[2*n];
            end
        end
    end

    assign any_o   = g_lvl[LVLS].vld[0];
    assign grant_o = any_o ? (DEPTH'(1) << g_lvl[LVLS].idx[0]) : '0;

endmodule

// File: rtl/instr_queue.sv
// Out-of-order issue queue: unordered slots with a wakeup CAM, oldest-ready select and
// age-based squash on branch mispredict.
module instr_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int PHYS_REGS = 64,
    parameter int PREG_W    = 6,
    parameter int CTR_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enq_valid,
    input  Instr_Queue_Entry_t         enq_entry,
    output logic                       enq_ready,
    input  logic [PHYS_REGS-1:0]       busy_bits,
    input  logic                       wb_valid,
    input  logic [PREG_W-1:0]          wb_phys,
    output logic                       iss_valid,
    output Instr_Queue_Entry_t         iss_entry,
    input  logic                       iss_ready,
    input  logic                       flush,
    input  logic [CTR_W-1:0]           flush_ctr,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       empty
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    logic [DEPTH-1:0]         vld_q, vld_d;
    logic [DEPTH-1:0]         rs_rdy_q, rs_rdy_d;
    logic [DEPTH-1:0]         rt_rdy_q, rt_rdy_d;
    Instr_Queue_Entry_t [DEPTH-1:0] slot_q, slot_d;

    logic [DEPTH-1:0][IQ_CTR_W-1:0] slot_ctr;
    logic [DEPTH-1:0]         req;
    logic [DEPTH-1:0]         grant;
    logic                     any_req;
    logic                     free_found;
    logic [IDX_W-1:0]         free_idx;
    logic                     do_enq, do_iss;
    logic                     enq_rs_rdy, enq_rt_rdy;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_ctr[i] = slot_q[i].count;
            req[i]      = vld_q[i] & rs_rdy_q[i] & rt_rdy_q[i];
        end
    end

    iq_oldest_select #(.DEPTH(DEPTH)) u_select (
        .req_i   (req),
        .count_i (slot_ctr),
        .grant_o (grant),
        .any_o   (any_req)
    );

    always_comb begin
        occupancy  = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(vld_q[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign empty     = (occupancy == '0);
    assign enq_ready = (occupancy != OCC_W'(DEPTH));
    assign iss_valid = any_req && !flush;
    assign do_iss    = iss_valid && iss_ready;
    assign do_enq    = enq_valid && enq_ready && free_found && !flush;

    always_comb begin
        iss_entry = slot_q[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                iss_entry = slot_q[i];
            end
        end
        iss_entry.ready = 1'b1;
    end

    // A source being written back this very cycle counts as ready on entry.
    assign enq_rs_rdy = !enq_entry.uses_rs || !busy_bits[enq_entry.rs_phys] ||
                        (wb_valid && wb_phys == enq_entry.rs_phys);
    assign enq_rt_rdy = !enq_entry.uses_rt || !busy_bits[enq_entry.rt_phys] ||
                        (wb_valid && wb_phys == enq_entry.rt_phys);

    always_comb begin
        vld_d    = vld_q;
        rs_rdy_d = rs_rdy_q;
        rt_rdy_d = rt_rdy_q;
        slot_d   = slot_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wb_valid && vld_q[i] && slot_q[i].uses_rs && slot_q[i].rs_phys == wb_phys) begin
                rs_rdy_d[i] = 1'b1;
            end
            if (wb_valid && vld_q[i] && slot_q[i].uses_rt && slot_q[i].rt_phys == wb_phys) begin
                rt_rdy_d[i] = 1'b1;
            end
            if (do_iss && grant[i]) begin
                vld_d[i] = 1'b0;
            end
            // Squash anything strictly younger than the mispredicted branch.
            if (flush && vld_q[i] && is_older(flush_ctr, slot_q[i].count)) begin
                vld_d[i] = 1'b0;
            end
        end
        if (do_enq) begin
            vld_d[free_idx]    = 1'b1;
            slot_d[free_idx]   = enq_entry;
            rs_rdy_d[free_idx] = enq_rs_rdy;
            rt_rdy_d[free_idx] = enq_rt_rdy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            rs_rdy_q <= '0;
            rt_rdy_q <= '0;
            slot_q   <= '0;
        end else begin
            vld_q    <= vld_d;
            rs_rdy_q <= rs_rdy_d;
            rt_rdy_q <= rt_rdy_d;
            slot_q   <= slot_d;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Scenario bench for instr_queue: expected issue order is queued as stimulus is driven
// and checked by a monitor whenever an issue handshake completes.
module tb_instr_queue;
    import mips_core_pkg::*;

    localparam int DEPTH     = 16;
    localparam int PHYS_REGS = 64;
    localparam int PREG_W    = 6;
    localparam int CTR_W     = 32;

    logic                   clk;
    logic                   rst;
    logic                   enq_valid;
    Instr_Queue_Entry_t     enq_entry;
    logic                   enq_ready;
    logic [PHYS_REGS-1:0]   busy_bits;
    logic                   wb_valid;
    logic [PREG_W-1:0]      wb_phys;
    logic                   iss_valid;
    Instr_Queue_Entry_t     iss_entry;
    logic                   iss_ready;
    logic                   flush;
    logic [CTR_W-1:0]       flush_ctr;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   empty;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    instr_queue #(.DEPTH(DEPTH), .PHYS_REGS(PHYS_REGS), .PREG_W(PREG_W), .CTR_W(CTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enq_valid (enq_valid),
        .enq_entry (enq_entry),
        .enq_ready (enq_ready),
        .busy_bits (busy_bits),
        .wb_valid  (wb_valid),
        .wb_phys   (wb_phys),
        .iss_valid (iss_valid),
        .iss_entry (iss_entry),
        .iss_ready (iss_ready),
        .flush     (flush),
        .flush_ctr (flush_ctr),
        .occupancy (occupancy),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic Instr_Queue_Entry_t mk(input logic [31:0] c,
                                              input logic [5:0] rs, input logic urs,
                                              input logic [5:0] rt, input logic urt);
        Instr_Queue_Entry_t e;
        e = '0;
        e.count   = c;
        e.rs_phys = rs;
        e.uses_rs = urs;
        e.rt_phys = rt;
        e.uses_rt = urt;
        e.rw_phys = 6'd7;
        e.uses_rw = 1'b1;
        e.pc      = c << 2;
        return e;
    endfunction

    task automatic idle();
        enq_valid = 1'b0;
        enq_entry = '0;
        wb_valid  = 1'b0;
        wb_phys   = '0;
        flush     = 1'b0;
        flush_ctr = '0;
    endtask

    task automatic enq(input Instr_Queue_Entry_t e);
        @(negedge clk);
        idle();
        enq_valid = 1'b1;
        enq_entry = e;
    endtask

    // Issue monitor: samples 1ns before each rising edge.
    always begin
        logic [31:0] exp_c;
        @(negedge clk);
        #4;
        if (!rst && iss_valid && iss_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected got count=%08h expected no issue", iss_entry.count);
            end else begin
                exp_c = sb.pop_front();
                if (iss_entry.count !== exp_c) begin
                    errors++;
                    $display("FAIL issue_order got count=%08h expected %08h", iss_entry.count, exp_c);
                end
            end
            checks++;
            if (iss_entry.ready !== 1'b1) begin
                errors++;
                $display("FAIL issue_ready_bit got %b expected 1", iss_entry.ready);
            end
        end
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0 (next count=%08h)", sb.size(), sb[0]);
            sb.delete();
        end
    endtask

    task automatic check_occ(input string name, input int exp_occ);
        checks++;
        if (occupancy !== exp_occ[$clog2(DEPTH):0]) begin
            errors++;
            $display("FAIL %s occupancy got %0d expected %0d", name, occupancy, exp_occ);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        busy_bits = '0;
        iss_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_occ("reset", 0);
        checks++;
        if (empty !== 1'b1 || enq_ready !== 1'b1 || iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got empty=%b enq_ready=%b iss_valid=%b expected 1 1 0",
                     empty, enq_ready, iss_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        iss_ready = 1'b1;
        enq(mk(32'd5, 6'd1, 1'b1, 6'd2, 1'b1));
        sb.push_back(32'd5);
        #1;
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_same_cycle iss_valid got %b expected 0", iss_valid);
        end
        @(negedge clk);
        idle();
        #1;
        check_occ("basic_after_enq", 1);
        checks++;
        if (iss_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_next_cycle iss_valid got %b expected 1", iss_valid);
        end
        @(negedge clk);
        #1;
        check_occ("basic_after_issue", 0);
        wait_drain(5);
    endtask

    task automatic test_wakeup();
        iss_ready = 1'b1;
        busy_bits[40] = 1'b1;
        enq(mk(32'd7, 6'd40, 1'b1, 6'd3, 1'b0));
        enq(mk(32'd8, 6'd1, 1'b1, 6'd2, 1'b1));
        sb.push_back(32'd8);
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL wakeup_blocked iss_valid got %b expected 0", iss_valid);
        end
        check_occ("wakeup_waiting", 1);
        @(negedge clk);
        wb_valid = 1'b1;
        wb_phys  = 6'd40;
        sb.push_back(32'd7);
        #1;
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL wakeup_same_cycle iss_valid got %b expected 0", iss_valid);
        end
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (iss_valid !== 1'b1) begin
            errors++;
            $display("FAIL wakeup_next_cycle iss_valid got %b expected 1", iss_valid);
        end
        busy_bits[40] = 1'b0;
        wait_drain(5);
    endtask

    task automatic test_bypass();
        iss_ready = 1'b1;
        busy_bits[33] = 1'b1;
        enq(mk(32'd9, 6'd0, 1'b0, 6'd33, 1'b1));
        wb_valid = 1'b1;
        wb_phys  = 6'd33;
        sb.push_back(32'd9);
        @(negedge clk);
        idle();
        #1;
        checks++;
        if (iss_valid !== 1'b1) begin
            errors++;
            $display("FAIL bypass iss_valid got %b expected 1", iss_valid);
        end
        wait_drain(5);
        busy_bits[33] = 1'b0;
    endtask

    task automatic test_full();
        iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            enq(mk(32'd100 + 32'(i), 6'd1, 1'b1, 6'd2, 1'b1));
        end
        enq(mk(32'd99, 6'd1, 1'b1, 6'd2, 1'b1));
        #1;
        checks++;
        if (enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_enq_ready got %b expected 0", enq_ready);
        end
        check_occ("full", 16);
        @(negedge clk);
        idle();
        iss_ready = 1'b1;
        sb.push_back(32'd100);
        #1;
        check_occ("full_17th_dropped", 16);
        @(negedge clk);
        iss_ready = 1'b0;
        #1;
        checks++;
        if (enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_after_issue enq_ready got %b expected 1", enq_ready);
        end
        check_occ("full_after_issue", 15);
        for (int i = 1; i < DEPTH; i++) sb.push_back(32'd100 + 32'(i));
        iss_ready = 1'b1;
        wait_drain(40);
        #1;
        check_occ("full_drained", 0);
    endtask

    task automatic test_flush();
        iss_ready = 1'b0;
        busy_bits[50] = 1'b1;
        for (int c = 10; c <= 14; c++) begin
            enq(mk(32'(c), 6'd50, 1'b1, 6'd2, 1'b0));
        end
        enq(mk(32'd15, 6'd1, 1'b1, 6'd2, 1'b1));
        flush     = 1'b1;
        flush_ctr = 32'd11;
        @(negedge clk);
        idle();
        #1;
        check_occ("flush_survivors", 2);
        @(negedge clk);
        wb_valid  = 1'b1;
        wb_phys   = 6'd50;
        iss_ready = 1'b1;
        sb.push_back(32'd10);
        sb.push_back(32'd11);
        @(negedge clk);
        idle();
        wait_drain(10);
        busy_bits[50] = 1'b0;
        #1;
        check_occ("flush_drained", 0);
    endtask

    task automatic test_wrap();
        iss_ready = 1'b0;
        enq(mk(32'h0000_0001, 6'd1, 1'b1, 6'd2, 1'b1));
        enq(mk(32'hFFFF_FFFE, 6'd1, 1'b1, 6'd2, 1'b1));
        @(negedge clk);
        idle();
        flush     = 1'b1;
        flush_ctr = 32'h0000_0001;
        iss_ready = 1'b1;
        #1;
        checks++;
        if (iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_issue iss_valid got %b expected 0", iss_valid);
        end
        @(negedge clk);
        idle();
        sb.push_back(32'hFFFF_FFFE);
        sb.push_back(32'h0000_0001);
        #1;
        check_occ("wrap_retained", 2);
        wait_drain(10);
    endtask

    task automatic test_reset_mid();
        iss_ready = 1'b0;
        enq(mk(32'd20, 6'd1, 1'b1, 6'd2, 1'b1));
        enq(mk(32'd21, 6'd1, 1'b1, 6'd2, 1'b1));
        @(negedge clk);
        idle();
        #1;
        check_occ("mid_before_reset", 2);
        #1;
        rst = 1'b1;
        #1;
        check_occ("mid_async_reset", 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_flush();
        test_wrap();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

Out-of-order instruction queue that sits directly after register renaming. It accepts one renamed instruction per cycle and holds it until both physical source operands are ready, tracking readiness through writeback wakeups. Each cycle it issues the oldest ready instruction to the execute stage. On a branch mispredict it squashes every entry younger than the branch.

## Interface
Parameters:
- DEPTH, 16, number of queue slots (power of two)
- PHYS_REGS, 64, physical register count
- PREG_W, 6, physical register index width
- CTR_W, 32, width of the instruction age tag (`count`)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- enq_valid  input  1  renamed instruction present (rename `instr_wr`)
- enq_entry  input  Instr_Queue_Entry_t  renamed instruction (rs/rt/rw_phys, uses_*, count, ALU/branch/mem fields)
- enq_ready  output  1  queue can accept this cycle
- busy_bits  input  PHYS_REGS  physical register busy table, 1 = value not yet produced
- wb_valid  input  1  a result is being written this cycle
- wb_phys  input  PREG_W  destination physical register of that result
- iss_valid  output  1  iss_entry is a ready instruction
- iss_entry  output  Instr_Queue_Entry_t  oldest ready instruction, with `ready` = 1
- iss_ready  input  1  execute stage accepts iss_entry
- flush  input  1  branch mispredict squash
- flush_ctr  input  CTR_W  count of the mispredicted branch
- occupancy  output  $clog2(DEPTH)+1  valid slot count
- empty  output  1  occupancy == 0

## Operation
- Slot state: valid, entry, rs_rdy, rt_rdy. Slots are unordered; age comes from `count` only.
- Age rule: a is older than b iff $signed(a.count − b.count) < 0 (CTR_W-bit subtraction). This tolerates counter wrap as long as live entries span fewer than 2^(CTR_W−1).
- Enqueue (enq_valid && enq_ready): the entry is written into the lowest-index free slot.
  - rs_rdy = !uses_rs || !busy_bits[rs_phys] || (wb_valid && wb_phys == rs_phys). rt_rdy is computed the same way.
  - The same-cycle wakeup bypass is mandatory.
- Wakeup: when wb_valid is high, every valid slot whose rs_phys (or rt_phys) equals wb_phys sets the matching rdy bit. A slot that does not use that source ignores the match.
- Select: among valid slots with rs_rdy && rt_rdy, choose the oldest by the age rule.
  - iss_valid = such a slot exists && !flush.
  - iss_entry is driven combinationally from that slot.
- Issue: when iss_valid && iss_ready, the selected slot is cleared at the clock edge.
- Flush: every valid slot with $signed(count − flush_ctr) > 0 is cleared.
  - The branch itself and all older entries are retained.
  - A concurrent enqueue is dropped.
  - No issue occurs in a flush cycle.
- enq_ready = occupancy < DEPTH. It does not depend on a same-cycle issue, so it is conservative.
- A wb_phys that matches no slot has no effect.

## Timing
- Reset: all slots invalid, occupancy 0, empty 1, enq_ready 1, iss_valid 0. Asserting rst mid-operation discards all entries immediately.
- Enqueue in cycle N → the entry is issuable in cycle N+1 at the earliest.
- Wakeup in cycle N → the dependent entry is issuable in N+1.
- Issue handshake: the entry leaves on the edge ending a cycle with iss_valid && iss_ready. With iss_ready low, the same or an older entry is presented next cycle.
- Simultaneous enqueue + issue: occupancy is unchanged. The freed slot is reusable from N+1.
- Simultaneous enqueue + wakeup of the same register: the entry enters ready (bypass).
- Flush + wakeup in the same cycle: wakeup applies to surviving slots.
- occupancy and empty update on the edge following any enqueue, issue, or flush.

## Structure
- Instr_Queue_Entry_t stays in mips_core_pkg, which is shared with rename.
- Add to mips_core_pkg a helper function `is_older(a, b)` implementing the age rule. Rename and the branch stack reuse it.
- Sub-module iq_oldest_select: a combinational, parameterized-DEPTH tree.
  - Inputs: per-slot request bits and counts.
  - Outputs: a one-hot grant plus an any-grant bit.
- instr_queue holds the slot storage, wakeup CAM, enqueue allocation, and flush/issue updates.

## Test plan
- Reset, then enqueue count=5 with sources not busy and iss_ready=1 → iss_valid in the next cycle with count 5. occupancy goes 1 → 0.
- Enqueue count=7 with rs_phys=40 busy, then count=8 ready → 8 issues first. Then pulse wb_valid with wb_phys=40 → 7 issues the next cycle.
- Enqueue count=9 with rt_phys=33 busy while wb_valid=1 and wb_phys=33 in the same cycle → issuable the next cycle (bypass check).
- Fill 16 entries with iss_ready=0 → enq_ready=0 and occupancy=16. A 17th enq_valid is ignored. One issue → enq_ready=1 the next cycle.
- Queue holds counts 10–14 (all busy) and flush with flush_ctr=11 → only 10 and 11 remain, occupancy=2. A same-cycle enqueue of 15 is dropped.
- Wrap case: counts 0xFFFFFFFE and 0x00000001 both ready → 0xFFFFFFFE issues first.
